mdio_master: RTL
================

Name: mdio_master

Overview:
- Clause-22 MDIO management master. Executes single read or write frames to an external PHY on request from the tester's host/register block.
- Generates MDC by dividing the system clock and drives/samples MDIO through separate o/oe/i signals. The pad tristate is at top level.
- Sits between the configuration register file and the PHY management pins. It sequences all PHY register accesses: reset, auto-negotiation setup, link-status reads.

Parameters:
- CLK_DIV, 10: MDC half-period in clk cycles. MDC = clk/(2*CLK_DIV). Legal values >= 2.
- PRE_LEN, 32: preamble length in bits, all ones.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  1  request present
- req_ready  output  1  master can accept a request (high only in IDLE)
- req_rw  input  1  1 = read, 0 = write
- req_phy  input  5  PHY address
- req_reg  input  5  register address
- req_wdata  input  16  write data
- rd_data  output  16  read data, valid from the done pulse until the next accept
- rd_err  output  1  read TA error, valid with rd_data
- done  output  1  one-clk pulse at frame end
- busy  output  1  frame in progress
- mdc  output  1  management clock
- mdio_o  output  1  MDIO drive value
- mdio_oe  output  1  MDIO drive enable
- mdio_i  input  1  MDIO pad input

Behaviour:
- Clock/reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values: req_ready=1, busy=0, done=0, rd_data=0, rd_err=0, mdc=0, mdio_o=1, mdio_oe=0. State = IDLE, divider count = 0, bit count = 0.
- Reset mid-frame: all of the above take effect on the next clk edge. The frame is abandoned and no done pulse is issued.
- Handshake: a request is accepted on a clk edge where req_valid & req_ready. Request fields are registered at accept; later input changes are ignored.
  - busy=1 and req_ready=0 from the cycle after accept until the cycle after done.
  - req_valid while busy is held off, not dropped.
- Bit timing: each bit period is 2*CLK_DIV clks.
  - mdc is low for the first CLK_DIV clks, then high for CLK_DIV clks.
  - mdio_o/mdio_oe update at the start of the bit (mdc low phase).
  - mdio_i is sampled on the clk where mdc goes 0->1.
  - mdc idles low; first mdc low phase begins the clk after accept.
- States and bit counts:
  - IDLE
  - PRE: PRE_LEN bits of 1, oe=1
  - ST: 01
  - OP: 10 for read, 01 for write
  - PHYAD: 5 bits, MSB first
  - REGAD: 5 bits, MSB first
  - TA: 2 bits. Write drives 1,0. Read sets oe=0 for both bits; the 2nd TA sample must be 0, otherwise rd_err=1.
  - DATA: 16 bits, MSB first. Write drives req_wdata. Read sets oe=0 and shifts mdio_i into the rd_data shift register.
  - DONE: one clk; done=1, mdc=0, oe=0, mdio_o=1; then IDLE.
- Transitions: on the last bit of each field, move to the next state. A bit counter reloads per field.
- rd_data/rd_err update only in DONE of a read. A write leaves both unchanged.
- Frame length: PRE_LEN+32 bits. Latency from accept to done = 1 + (PRE_LEN+32)*2*CLK_DIV clks. Defaults: 1281 clks.
- No PHY present (bus pulled up): a read returns rd_data=16'hFFFF, rd_err=1.
- Divider and bit counters are sized from CLK_DIV and PRE_LEN with $clog2. There is no wrap-around within a frame.

Optional Feature:
- MDIO_PRE_SUPPRESS_EN.
- Defined: adds input pre_sup (1 bit), registered at accept. When 1, the PRE state is skipped: frame is 32 bits, latency 1+64*CLK_DIV clks.
- Undefined: no pre_sup port; the preamble is always sent.

Test Plan:
- Write phy=1, reg=0, wdata=16'h1140 -> MDIO bit stream 32x1, 01, 01, 00001, 00000, 10, 0001000101000000; done pulses exactly 1281 clks after accept; PHY BFM register 0 = 16'h1140.
- Read phy=1, reg=1 against the PHY BFM (reg1=16'h796d) -> oe=0 during TA/DATA; rd_data=16'h796d, rd_err=0 at done.
- No PHY attached (mdio_i tied 1), read reg 2 -> rd_data=16'hFFFF, rd_err=1; done still issued.
- Second req_valid asserted 100 clks into a frame -> req_ready=0 until the cycle after done; the second request is then accepted and its frame starts.
- rst=1 during PHYAD of a write -> next clk mdc=0, oe=0, busy=0, req_ready=1, no done; a following read completes normally.
- With MDIO_PRE_SUPPRESS_EN, pre_sup=1 read -> the first driven bit is ST 0; done at 1+64*CLK_DIV clks (641 by default).

Source files
------------

// File: rtl/mdio_master.sv
// Clause-22 MDIO master: accept-to-done 1+(PRE_LEN+32)*2*CLK_DIV clks, req_ready only in IDLE so requests wait while busy.
// Optional `MDIO_PRE_SUPPRESS_EN adds pre_sup, which skips the preamble (32-bit frame).
module mdio_master #(
  parameter int CLK_DIV = 10,
  parameter int PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_rw,
  input  logic [4:0]  req_phy,
  input  logic [4:0]  req_reg,
  input  logic [15:0] req_wdata,
`ifdef MDIO_PRE_SUPPRESS_EN
  input  logic        pre_sup,
`endif
  output logic [15:0] rd_data,
  output logic        rd_err,
  output logic        done,
  output logic        busy,
  output logic        mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam int DW = $clog2(2 * CLK_DIV);
  localparam int BW = $clog2((PRE_LEN > 16) ? PRE_LEN : 16);
  localparam logic [DW-1:0] DIV_RISE = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_HIGH = DW'(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(2 * CLK_DIV - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_DONE
  } state_t;

  state_t        state_q, state_d, next_field;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d, last_bit;
  logic [31:0]   sh_q, sh_d;
  logic          rw_q, rw_d;
  logic [15:0]   rdsh_q, rdsh_d;
  logic          ta_err_q, ta_err_d;
  logic [15:0]   rd_data_q, rd_data_d;
  logic          rd_err_q, rd_err_d;

  // Field lengths and the field that follows each one.
  always_comb begin
    last_bit   = BW'(1);
    next_field = S_IDLE;
    case (state_q)
      S_PRE:   begin last_bit = BW'(PRE_LEN - 1); next_field = S_ST;    end
      S_ST:    begin last_bit = BW'(1);           next_field = S_OP;    end
      S_OP:    begin last_bit = BW'(1);           next_field = S_PHYAD; end
      S_PHYAD: begin last_bit = BW'(4);           next_field = S_REGAD; end
      S_REGAD: begin last_bit = BW'(4);           next_field = S_TA;    end
      S_TA:    begin last_bit = BW'(1);           next_field = S_DATA;  end
      S_DATA:  begin last_bit = BW'(15);          next_field = S_DONE;  end
      default: begin last_bit = BW'(1);           next_field = S_IDLE;  end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    bit_d     = bit_q;
    sh_d      = sh_q;
    rw_d      = rw_q;
    rdsh_d    = rdsh_q;
    ta_err_d  = ta_err_q;
    rd_data_d = rd_data_q;
    rd_err_d  = rd_err_q;
    req_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;
    mdc       = 1'b0;
    mdio_o    = 1'b1;
    mdio_oe   = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
`ifdef MDIO_PRE_SUPPRESS_EN
          state_d = pre_sup ? S_ST : S_PRE;
`else
          state_d = S_PRE;
`endif
          div_d    = '0;
          bit_d    = '0;
          sh_d     = {2'b01, (req_rw ? 2'b10 : 2'b01), req_phy, req_reg, 2'b10, req_wdata};
          rw_d     = req_rw;
          ta_err_d = 1'b0;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        mdc     = (div_q >= DIV_HIGH);
        mdio_oe = !(rw_q && (state_q == S_TA || state_q == S_DATA));
        mdio_o  = (state_q == S_PRE) ? 1'b1 : sh_q[31];
        div_d   = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
        // PHY-driven bits are captured on the clk where mdc rises.
        if (div_q == DIV_RISE) begin
          if (state_q == S_TA && bit_q == BW'(1))
            ta_err_d = mdio_i;
          if (state_q == S_DATA)
            rdsh_d = {rdsh_q[14:0], mdio_i};
        end
        if (div_q == DIV_LAST) begin
          if (state_q != S_PRE)
            sh_d = {sh_q[30:0], 1'b1};
          if (bit_q == last_bit) begin
            bit_d   = '0;
            state_d = next_field;
            if (state_q == S_DATA && rw_q) begin
              rd_data_d = rdsh_q;
              rd_err_d  = ta_err_q;
            end
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      div_q     <= '0;
      bit_q     <= '0;
      sh_q      <= '0;
      rw_q      <= 1'b0;
      rdsh_q    <= '0;
      ta_err_q  <= 1'b0;
      rd_data_q <= '0;
      rd_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      sh_q      <= sh_d;
      rw_q      <= rw_d;
      rdsh_q    <= rdsh_d;
      ta_err_q  <= ta_err_d;
      rd_data_q <= rd_data_d;
      rd_err_q  <= rd_err_d;
    end
  end

  assign rd_data = rd_data_q;
  assign rd_err  = rd_err_q;

endmodule
